// File: rtl/rr_merge_arbiter_pkg.sv
// Shared types and helpers for the round-robin merge arbiter and its priority encoder.
package rr_merge_arbiter_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   localparam int DEF_N     = 4;
   localparam int DEF_WIDTH = 8;

   // ceil(log2(n)), never less than 1 so a 2-entry arbiter still gets a real index bit.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_merge_arbiter_if.sv
// N-requester flit bundle plus the merged output channel; slave is the arbiter's view.
interface rr_merge_arbiter_if
   import rr_merge_arbiter_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDXW  = idx_width(N)
);
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_last;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_last;
   logic [IDXW-1:0]    out_sel;

   modport slave (
      input  in_valid, in_last, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, out_sel
   );

   modport master (
      output in_valid, in_last, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_sel
   );
endinterface

// File: rtl/rr_merge_arbiter_pick.sv
// Rotate-priority encoder: first asserted req at or after ptr, wrapping mod N.
// Purely combinational, no latency; no backpressure of its own.
module rr_pick
   import rr_merge_arbiter_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int IDXW = idx_width(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic            gnt_valid,
   output logic [IDXW-1:0] gnt_idx
);

   logic [IDXW-1:0] j;

   // Walk from the farthest offset back to ptr so the nearest requester is the last writer.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      j         = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = IDXW'((int'(ptr) + k) % N);
         if (req[j]) begin
            gnt_valid = 1'b1;
            gnt_idx   = j;
         end
      end
   end

endmodule

// File: rtl/rr_merge_arbiter.sv
// Round-robin N:1 packet merge with grant lock until last flit; 1-cycle latency through one output register.
// Backpressure: a full, stalled output register drops every in_ready; a locked owner stalls all others.
module rr_merge_arbiter
   import rr_merge_arbiter_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDXW  = idx_width(N)
) (
   input logic               clk,
   input logic               rst,
   rr_merge_arbiter_if.slave bus
);

   arb_state_t      state, nxt_state;
   logic [IDXW-1:0] ptr, nxt_ptr;
   logic [IDXW-1:0] owner, nxt_owner;
   logic [IDXW-1:0] sel_idx;
   logic [IDXW-1:0] gnt_idx;
   logic            gnt_valid;
   logic            space;
   logic            load;
   logic [N-1:0]    rdy;
   logic [WIDTH-1:0] lane [N];

   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_last_q;
   logic [IDXW-1:0]  out_sel_q;

   for (genvar i = 0; i < N; i++) begin : g_lane
      assign lane[i] = bus.in_data[i*WIDTH +: WIDTH];
   end

   rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
      .req       (bus.in_valid),
      .ptr       (ptr),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   assign space = !out_valid_q || bus.out_ready;

   always_comb begin
      nxt_state = state;
      nxt_ptr   = ptr;
      nxt_owner = owner;
      sel_idx   = gnt_idx;
      load      = 1'b0;
      rdy       = '0;
      unique case (state)
         ARB: begin
            if (space && gnt_valid) begin
               rdy[gnt_idx] = 1'b1;
               load         = 1'b1;
               nxt_ptr      = (gnt_idx == IDXW'(N - 1)) ? '0 : gnt_idx + IDXW'(1);
               if (!bus.in_last[gnt_idx]) begin
                  nxt_owner = gnt_idx;
                  nxt_state = LOCKED;
               end
            end
         end
         LOCKED: begin
            // Owner keeps the channel even while it idles mid-packet.
            sel_idx    = owner;
            rdy[owner] = space;
            if (space && bus.in_valid[owner]) begin
               load = 1'b1;
               if (bus.in_last[owner]) nxt_state = ARB;
            end
         end
         default: nxt_state = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ARB;
         ptr         <= '0;
         owner       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_sel_q   <= '0;
      end else begin
         state <= nxt_state;
         ptr   <= nxt_ptr;
         owner <= nxt_owner;
         if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= lane[sel_idx];
            out_last_q  <= bus.in_last[sel_idx];
            out_sel_q   <= sel_idx;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_merge_arbiter.sv
// Directed and random checks of rr_merge_arbiter against a packet-level round-robin reference model.
module tb_rr_merge_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rr_merge_arbiter_if #(.N(N), .WIDTH(W), .IDXW(2)) bus ();
   rr_merge_arbiter #(.N(N), .WIDTH(W), .IDXW(2)) dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   logic [N-1:0] v, l;
   logic [W-1:0] d [N];
   logic         ordy;
   logic [N-1:0] last_rdy;

   // Reference state: owner < 0 means no packet in progress.
   int           m_ptr, m_owner, m_os;
   logic         m_ov, m_ol;
   logic [W-1:0] m_od;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_owner = -1; m_os = 0; m_ov = 1'b0; m_ol = 1'b0; m_od = '0;
   endtask

   // One clock: drive, check in_ready before the edge, step the model, check outputs after it.
   task automatic step();
      logic [N-1:0] exp_rdy;
      logic         space;
      int           win;
      bus.in_valid  = v;
      bus.in_last   = l;
      bus.in_data   = {d[3], d[2], d[1], d[0]};
      bus.out_ready = ordy;
      #1;
      space   = !m_ov || ordy;
      exp_rdy = '0;
      win     = -1;
      if (m_owner < 0) begin
         if (space) begin
            for (int k = 0; k < N; k++) begin
               if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
         end
      end else if (space) begin
         exp_rdy[m_owner] = 1'b1;
         if (v[m_owner]) win = m_owner;
      end
      last_rdy = bus.in_ready;
      check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (rst) begin
         model_reset();
      end else if (win >= 0) begin
         m_ov = 1'b1; m_od = d[win]; m_ol = l[win]; m_os = win;
         if (m_owner < 0) begin
            m_ptr = (win + 1) % N;
            if (!l[win]) m_owner = win;
         end else if (l[win]) begin
            m_owner = -1;
         end
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      @(posedge clk);
      #1;
      check("out_valid", 32'(bus.out_valid), 32'(m_ov));
      check("out_data",  32'(bus.out_data),  32'(m_od));
      check("out_last",  32'(bus.out_last),  32'(m_ol));
      check("out_sel",   32'(bus.out_sel),   32'(m_os));
      @(negedge clk);
   endtask

   task automatic lane(input int i, input logic vv, input logic ll, input logic [W-1:0] dd);
      v[i] = vv; l[i] = ll; d[i] = dd;
   endtask

   initial begin
      v = '0; l = '0; ordy = 1'b1;
      for (int i = 0; i < N; i++) d[i] = '0;
      bus.in_valid = '0; bus.in_last = '0; bus.in_data = '0; bus.out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      step();
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_in_ready", 32'(last_rdy), 32'd0);
      rst = 1'b0;

      // Single requester 2
      lane(2, 1, 1, 8'h5A);
      step();
      check("single_rdy", 32'(last_rdy), 32'b0100);
      check("single_data", 32'(bus.out_data), 32'h5A);
      check("single_sel", 32'(bus.out_sel), 32'd2);
      check("single_last", 32'(bus.out_last), 32'd1);
      // ptr should now be 3: with 0,2,3 requesting, 3 wins
      lane(0, 1, 1, 8'h00); lane(3, 1, 1, 8'h03);
      step();
      check("ptr_after_single", 32'(bus.out_sel), 32'd3);

      // Full contention, data = index
      for (int i = 0; i < N; i++) lane(i, 1, 1, W'(i));
      for (int k = 0; k < 8; k++) begin
         step();
         check("rr_sel", 32'(bus.out_sel), 32'(k % N));
         check("rr_nobubble", 32'(bus.out_valid), 32'd1);
      end

      // Packet lock: move ptr to 1, then req1 sends 3 flits against req0 and req3
      v = '0;
      lane(0, 1, 1, 8'hA0);
      step();
      lane(1, 1, 0, 8'h11); lane(3, 1, 1, 8'h33);
      step(); check("lock_f1", 32'(bus.out_sel), 32'd1);
      lane(1, 1, 0, 8'h12);
      step(); check("lock_f2", 32'(bus.out_sel), 32'd1);
      lane(1, 1, 1, 8'h13);
      step(); check("lock_f3", 32'({bus.out_sel, bus.out_data}), 32'h113);
      lane(1, 0, 0, 8'h00);
      step(); check("lock_then3", 32'(bus.out_sel), 32'd3);
      lane(3, 0, 0, 8'h00);
      step(); check("lock_then0", 32'(bus.out_sel), 32'd0);
      lane(0, 0, 0, 8'h00);
      step();

      // Backpressure with a held flit
      lane(2, 1, 1, 8'hA0);
      step();
      ordy = 1'b0; lane(2, 1, 1, 8'hA1);
      for (int k = 0; k < 3; k++) begin
         step();
         check("bp_rdy", 32'(last_rdy), 32'd0);
         check("bp_hold", 32'({bus.out_valid, bus.out_data}), 32'h1A0);
      end
      ordy = 1'b1;
      step(); check("bp_resume_rdy", 32'(last_rdy), 32'b0100);
      check("bp_resume", 32'(bus.out_data), 32'hA1);
      lane(2, 1, 1, 8'hA2);
      step(); check("bp_next", 32'(bus.out_data), 32'hA2);
      lane(2, 0, 0, 8'h00);
      step();

      // Owner stall while locked to req 2
      lane(2, 1, 0, 8'h21);
      step();
      lane(2, 0, 0, 8'h00); lane(0, 1, 1, 8'h0F);
      for (int k = 0; k < 2; k++) begin
         step();
         check("stall_no_req0", 32'(last_rdy[0]), 32'd0);
      end
      check("stall_drained", 32'(bus.out_valid), 32'd0);
      lane(2, 1, 1, 8'h22);
      step(); check("stall_last", 32'({bus.out_sel, bus.out_data}), 32'h222);
      lane(2, 0, 0, 8'h00);
      step(); check("stall_then0", 32'({bus.out_sel, bus.out_data}), 32'h00F);
      lane(0, 0, 0, 8'h00);

      // Reset during req 3's second flit
      lane(3, 1, 0, 8'h31);
      step();
      lane(3, 1, 0, 8'h32); rst = 1'b1;
      step();
      check("rst_mid", 32'({bus.out_valid, bus.out_last, bus.out_sel, bus.out_data}), 32'd0);
      rst = 1'b0;
      lane(1, 1, 1, 8'h41); lane(3, 1, 1, 8'h34);
      step();
      check("rst_rdy", 32'(last_rdy), 32'b0010);
      check("rst_first", 32'(bus.out_sel), 32'd1);

      // Random traffic against the reference model
      for (int c = 0; c < 1500; c++) begin
         v    = N'($urandom);
         ordy = ($urandom_range(0, 3) != 0);
         rst  = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < N; i++) begin
            l[i] = ($urandom_range(0, 4) < 2);
            d[i] = W'($urandom);
         end
         step();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rr_merge_arbiter.md
# rr_merge_arbiter

Clocked round-robin arbiter and merge for N requesters sharing one output channel. Each requester presents WIDTH-bit flits over valid/ready; the block picks one winner fairly, locks the grant for a multi-flit packet until the flit marked last, and forwards flits through a single-entry output register together with the winner index. It sits in front of any shared resource (router output port, shared PE bus) that several producers compete for.

## Interface
- N, default 4: number of requesters (N ≥ 2).
- WIDTH, default 8: flit data width.
- IDXW, default 2: winner index width, = ceil(log2 N).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  N  per-requester flit valid.
- in_last  in  N  per-requester "flit is last of packet".
- in_data  in  N*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  one-hot or zero; flit i transfers when in_valid[i] & in_ready[i].
- out_valid  out  1  output register holds a flit.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- out_data  out  WIDTH  registered flit.
- out_last  out  1  registered last flag.
- out_sel  out  IDXW  index of the requester that produced out_data.

## Operation
- State: ptr (IDXW, highest-priority index), lock (1 bit), owner (IDXW), output register {out_valid, out_data, out_last, out_sel}.
- FSM: ARB (lock=0) and LOCKED (lock=1).
- `space` = !out_valid | out_ready (output register can load this cycle).
- ARB: if space, winner = first i with in_valid[i], searching ptr, ptr+1, … mod N; in_ready[winner]=1, others 0. On transfer: load output register, out_sel=winner, ptr ← (winner+1) mod N; if !in_last[winner], owner ← winner and go LOCKED.
- LOCKED: in_ready[owner] = space; all others 0. On transfer, load register; if in_last[owner], lock ← 0, return to ARB. ptr is unchanged while LOCKED.
- Owner dropping in_valid mid-packet: stay LOCKED and stall; no other requester is granted.
- Single-flit packet (in_last=1 on first flit): stays in ARB.
- No requests in ARB: in_ready=0, ptr unchanged.
- Output side: if out_valid & !out_ready and no load, the register holds all fields stable.
- in_ready is combinational from in_valid, state, and out_ready. in_valid must not depend combinationally on in_ready.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=0, lock=0, owner=0, in_ready=0.
- Latency: a flit accepted at edge k appears on out_* after edge k, i.e. 1 cycle.
- Throughput: 1 flit/cycle when out_ready is held high (load and drain in the same cycle).
- Fairness: with all N requesting single-flit packets continuously, the grant order is 0,1,…,N-1,0,… Each requester waits at most N-1 packets.
- Reset asserted mid-packet: the cycle after the edge, all state is at reset values. The partial packet is abandoned and the next arbitration starts from requester 0.
- Simultaneous load and drain (out_valid & out_ready & new transfer): the register takes the new flit, and out_valid stays 1.

## Structure
- Shared package: arbiter state enum {ARB, LOCKED} and an index-width helper function (ceil log2).
- One sub-module: rr_pick, a combinational rotate-priority encoder. Inputs: req[N], ptr. Outputs: gnt_valid, gnt_idx. Reused by other arbiters.
- Top: FSM, ptr/owner registers, output register, and the data mux.

## Test plan
- Single requester: only req 2 sends a 1-flit packet with data 0x5A, out_ready=1 → in_ready=0100, next cycle out_data=0x5A, out_sel=2, out_last=1, ptr=3.
- Full contention: all 4 continuously send 1-flit packets, data = index, out_ready=1 → out_sel sequence 0,1,2,3,0,1,2,3 on consecutive cycles with no bubbles.
- Packet lock: req 1 sends a 3-flit packet (0x11, 0x12, 0x13 last) while req 0 and req 3 are valid → out_sel=1 for three flits, then out_sel=3, then out_sel=0.
- Backpressure: out_ready=0 for 3 cycles with a flit held → out_valid=1 and out_data stable, in_ready=0000. On release, one flit per cycle resumes with no loss or duplication.
- Owner stall: while locked to req 2, req 2 drops valid for 2 cycles while req 0 is valid → no grant to req 0 until req 2's last flit transfers.
- Reset mid-packet: rst for 1 cycle during req 3's second flit → all outputs 0 next cycle; with req 1 and req 3 valid afterwards, the first grant goes to req 1 (ptr=0).
